// File: rtl/fb_pkg.sv
// Constants and state type shared by the framebuffer writer and the TFT read client.
package fb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DATA
    } fb_state_e;

    localparam logic [23:0]     FB_BASE        = 24'hfa0000;
    localparam int unsigned     FB_FRAME_WORDS = 384000;

endpackage

// File: rtl/fb_burst_fifo.sv
// Two-slot burst FIFO: a slot commits on its BURST-th word; a sof word snaps the write
// pointer back to the slot start. Optional drop reporting under FB_WRITER_STATS_EN.
module fb_burst_fifo
    import fb_pkg::*;
#(
    parameter int unsigned DN    = 16,
    parameter int unsigned BURST = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          push,
    input  logic [DN-1:0]                 push_data,
    input  logic                          push_sof,
    input  logic                          pop,
    output logic                          full,
    output logic                          not_empty,
    output logic                          head_valid,
    output logic                          head_sof,
    output logic                          head_last,
    output logic [DN-1:0]                 head_data
`ifdef FB_WRITER_STATS_EN
    ,
    output logic [$clog2(BURST)-1:0]      drop_words
`endif
);

    localparam int unsigned IW = $clog2(BURST);

    logic [DN-1:0] mem_q [2*BURST];
    logic [DN-1:0] mem_d [2*BURST];
    logic          wslot_q, wslot_d, rslot_q, rslot_d;
    logic [IW-1:0] widx_q, widx_d, ridx_q, ridx_d;
    logic [1:0]    comm_q, comm_d, sof_q, sof_d;
    logic [IW-1:0] wr_idx;
    logic          wr_en;

    always_comb begin
        mem_d   = mem_q;
        wslot_d = wslot_q;
        widx_d  = widx_q;
        rslot_d = rslot_q;
        ridx_d  = ridx_q;
        comm_d  = comm_q;
        sof_d   = sof_q;

        full   = comm_q[wslot_q];
        wr_en  = push && !full;
        // a sof word always lands at word 0, discarding whatever partial data precedes it
        wr_idx = push_sof ? '0 : widx_q;

        if (wr_en) begin
            mem_d[{wslot_q, wr_idx}] = push_data;
            if (wr_idx == '0) begin
                sof_d[wslot_q] = push_sof;
            end
            if (wr_idx == IW'(BURST - 1)) begin
                comm_d[wslot_q] = 1'b1;
                wslot_d         = ~wslot_q;
                widx_d          = '0;
            end else begin
                widx_d = wr_idx + IW'(1);
            end
        end

        if (pop && comm_q[rslot_q]) begin
            if (ridx_q == IW'(BURST - 1)) begin
                comm_d[rslot_q] = 1'b0;
                rslot_d         = ~rslot_q;
                ridx_d          = '0;
            end else begin
                ridx_d = ridx_q + IW'(1);
            end
        end
    end

    assign not_empty  = (|comm_q) || (widx_q != '0);
    assign head_valid = comm_q[rslot_q];
    assign head_sof   = sof_q[rslot_q];
    assign head_last  = (ridx_q == IW'(BURST - 1));
    assign head_data  = mem_q[{rslot_q, ridx_q}];

`ifdef FB_WRITER_STATS_EN
    assign drop_words = (wr_en && push_sof) ? widx_q : '0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wslot_q <= 1'b0;
            rslot_q <= 1'b0;
            widx_q  <= '0;
            ridx_q  <= '0;
            comm_q  <= '0;
            sof_q   <= '0;
        end else begin
            wslot_q <= wslot_d;
            rslot_q <= rslot_d;
            widx_q  <= widx_d;
            ridx_q  <= ridx_d;
            comm_q  <= comm_d;
            sof_q   <= sof_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/fb_writer.sv
// Framebuffer burst writer on the SDRAM arbiter interface.
// Define FB_WRITER_STATS_EN to add the frame_cnt / drop_cnt statistics outputs.
module fb_writer
    import fb_pkg::*;
#(
    parameter int unsigned     AN          = 24,
    parameter int unsigned     DN          = 16,
    parameter int unsigned     BURST       = 8,
    parameter logic [AN-1:0]   BASE        = AN'(FB_BASE),
    parameter int unsigned     FRAME_WORDS = FB_FRAME_WORDS
) (
    input  logic               clkSYS,
    input  logic               reset,
    input  logic [DN-1:0]      pix_data,
    input  logic               pix_valid,
    input  logic               pix_sof,
    output logic               pix_ready,
    output logic               request,
    output logic [AN-1:0]      req_addr,
    output logic               req_wr,
    input  logic               req_ack,
    output logic [DN-1:0]      wr_data,
    output logic               wr_valid,
    output logic               busy
`ifdef FB_WRITER_STATS_EN
    ,
    output logic [15:0]        frame_cnt,
    output logic [15:0]        drop_cnt
`endif
);

    fb_state_e      state_q, state_d;
    logic [AN-1:0]  offset_q, offset_d;
    logic [AN-1:0]  req_addr_q, req_addr_d;
    logic           pop;
    logic           full, not_empty, head_valid, head_sof, head_last;
    logic [DN-1:0]  head_data;

`ifdef FB_WRITER_STATS_EN
    localparam int unsigned IW = $clog2(BURST);
    logic [IW-1:0]  drop_words;
    logic [16:0]    drop_sum;
    logic [15:0]    frame_cnt_q, frame_cnt_d, drop_cnt_q, drop_cnt_d;
`endif

    fb_burst_fifo #(
        .DN    (DN),
        .BURST (BURST)
    ) u_fifo (
        .clk        (clkSYS),
        .reset      (reset),
        .push       (pix_valid && pix_ready),
        .push_data  (pix_data),
        .push_sof   (pix_sof),
        .pop        (pop),
        .full       (full),
        .not_empty  (not_empty),
        .head_valid (head_valid),
        .head_sof   (head_sof),
        .head_last  (head_last),
        .head_data  (head_data)
`ifdef FB_WRITER_STATS_EN
        ,
        .drop_words (drop_words)
`endif
    );

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        req_addr_d = req_addr_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (head_valid) begin
                    state_d = REQ;
                    if (head_sof) begin
                        offset_d   = '0;
                        req_addr_d = BASE;
                    end else begin
                        req_addr_d = BASE + offset_q;
                    end
                end
            end
            REQ: begin
                if (req_ack) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                pop = 1'b1;
                if (head_last) begin
                    state_d = IDLE;
                    if (offset_q + AN'(BURST) == AN'(FRAME_WORDS)) begin
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q + AN'(BURST);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            state_q    <= IDLE;
            offset_q   <= '0;
            req_addr_q <= BASE;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            req_addr_q <= req_addr_d;
        end
    end

    // ready is forced low while reset is held so no word is taken during reset
    assign pix_ready = !full && !reset;
    assign request   = (state_q == REQ);
    assign req_wr    = request;
    assign req_addr  = req_addr_q;
    assign wr_valid  = (state_q == DATA);
    assign wr_data   = wr_valid ? head_data : '0;
    assign busy      = (state_q != IDLE) || not_empty;

`ifdef FB_WRITER_STATS_EN
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        // head_sof still describes the slot being drained until its last pop
        if (state_q == DATA && head_last && head_sof && frame_cnt_q != 16'hffff) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drop_words);
        drop_cnt_d = drop_sum[16] ? 16'hffff : drop_sum[15:0];
    end

    always_ff @(posedge clkSYS) begin
        if (reset) begin
            frame_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fb_writer.sv
// Self-checking bench for fb_writer: stream-level model plus directed literal checks.
// Build with FB_WRITER_STATS_EN defined to also check the statistics counters.
module tb_fb_writer;

    localparam int unsigned AN    = 24;
    localparam int unsigned DN    = 16;
    localparam int unsigned BURST = 8;
    localparam int unsigned FW    = 32;
    localparam logic [AN-1:0] BASE = 24'hfa0000;

    logic          clkSYS = 1'b0;
    logic          reset  = 1'b1;
    logic [DN-1:0] pix_data = '0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic          request;
    logic [AN-1:0] req_addr;
    logic          req_wr;
    logic          req_ack = 1'b0;
    logic [DN-1:0] wr_data;
    logic          wr_valid;
    logic          busy;
`ifdef FB_WRITER_STATS_EN
    logic [15:0]   frame_cnt, drop_cnt;
`endif

    always #5 clkSYS = ~clkSYS;

    fb_writer #(
        .AN          (AN),
        .DN          (DN),
        .BURST       (BURST),
        .BASE        (BASE),
        .FRAME_WORDS (FW)
    ) dut (
        .clkSYS    (clkSYS),
        .reset     (reset),
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_sof   (pix_sof),
        .pix_ready (pix_ready),
        .request   (request),
        .req_addr  (req_addr),
        .req_wr    (req_wr),
        .req_ack   (req_ack),
        .wr_data   (wr_data),
        .wr_valid  (wr_valid),
        .busy      (busy)
`ifdef FB_WRITER_STATS_EN
        ,
        .frame_cnt (frame_cnt),
        .drop_cnt  (drop_cnt)
`endif
    );

    int nvec = 0;
    int nmis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        nvec++;
        nmis++;
        $display("FAIL %s: bound expired or event missing (t=%0t)", name, $time);
    endtask

    // ---------------- stream-level model ----------------
    typedef struct packed {
        logic                  sof;
        logic [BURST*DN-1:0]   words;
    } burst_t;

    burst_t        bq[$];
    logic [DN-1:0] part[$];
    logic          part_sof = 1'b0;
    int unsigned   off = 0;
    bit            streaming = 0;
    bit            req_phase = 0;
    int unsigned   beat = 0;
    int unsigned   waitc = 0;
    bit            prev_rst = 0;
    int unsigned   m_drop = 0;
    int unsigned   m_frame = 0;
    burst_t        hb;
    bit            er;
    logic [AN-1:0] ea;

    logic [AN-1:0] addr_log[$];
    logic [DN-1:0] first_log[$];

    always @(negedge clkSYS) begin
        er = !reset && (bq.size() < 2);
        chk("pix_ready", 32'(pix_ready), 32'(er));
        chk("busy", 32'(busy), 32'(bq.size() != 0 || part.size() != 0));
        chk("wr_valid", 32'(wr_valid), 32'(streaming));
        if (prev_rst) begin
            chk("rst_req_addr", 32'(req_addr), 32'(BASE));
            chk("rst_request", 32'(request), 32'd0);
        end
`ifdef FB_WRITER_STATS_EN
        chk("frame_cnt", 32'(frame_cnt), m_frame);
        chk("drop_cnt", 32'(drop_cnt), m_drop);
`endif
        if (streaming) begin
            hb = bq[0];
            chk("wr_data", 32'(wr_data), 32'(hb.words[beat*DN +: DN]));
            chk("request_in_data", 32'(request), 32'd0);
            if (beat == 0) first_log.push_back(wr_data);
            waitc = 0;
        end else begin
            chk("wr_data_idle", 32'(wr_data), 32'd0);
            if (request) begin
                if (bq.size() == 0) begin
                    fail("request_without_burst");
                end else begin
                    hb = bq[0];
                    ea = hb.sof ? BASE : BASE + AN'(off);
                    chk("req_addr", 32'(req_addr), 32'(ea));
                    chk("req_wr", 32'(req_wr), 32'd1);
                    if (!req_phase) chk("req_gap", waitc, 32'd1);
                end
                req_phase = 1;
                waitc = 0;
            end else if (bq.size() != 0) begin
                chk("req_wr_low", 32'(req_wr), 32'd0);
                if (req_phase) begin
                    chk("req_hold", 32'(request), 32'd1);
                end else begin
                    chk("req_latency", waitc, 32'd0);
                    waitc++;
                end
            end else begin
                chk("req_wr_low", 32'(req_wr), 32'd0);
                waitc = 0;
            end
        end

        // advance the model to the state after the coming rising edge
        if (reset) begin
            bq.delete();
            part.delete();
            off = 0;
            streaming = 0;
            req_phase = 0;
            waitc = 0;
            m_drop = 0;
            m_frame = 0;
            prev_rst = 1;
        end else begin
            prev_rst = 0;
            if (streaming) begin
                beat++;
                if (beat == BURST) begin
                    hb = bq.pop_front();
                    if (hb.sof) off = 0;
                    off = off + BURST;
                    if (off == FW) off = 0;
                    if (hb.sof && m_frame < 65535) m_frame++;
                    streaming = 0;
                end
            end else if (request && req_ack) begin
                addr_log.push_back(req_addr);
                streaming = 1;
                beat = 0;
                req_phase = 0;
            end
            if (pix_valid && er) begin
                if (pix_sof) begin
                    m_drop = (m_drop + part.size() > 65535) ? 65535 : m_drop + part.size();
                    part.delete();
                end
                if (part.size() == 0) part_sof = pix_sof;
                part.push_back(pix_data);
                if (part.size() == BURST) begin
                    hb.sof = part_sof;
                    for (int i = 0; i < BURST; i++) hb.words[i*DN +: DN] = part[i];
                    bq.push_back(hb);
                    part.delete();
                end
            end
        end
    end

    // ---------------- arbiter stand-in ----------------
    int ack_delay = 3;
    int rc = 0;

    initial begin
        forever begin
            @(posedge clkSYS);
            #1;
            if (reset) begin
                req_ack = 1'b0;
                rc = 0;
            end else if (req_ack) begin
                req_ack = 1'b0;
            end else if (request) begin
                if (rc >= ack_delay) begin
                    req_ack = 1'b1;
                    rc = 0;
                end else begin
                    rc++;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clkSYS);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pix_valid = 1'b0;
        pix_sof = 1'b0;
        tick();
        @(negedge clkSYS);
        chk("reset_pix_ready", 32'(pix_ready), 32'd0);
        chk("reset_req_addr", 32'(req_addr), 32'hfa0000);
        chk("reset_wr_valid", 32'(wr_valid), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        addr_log.delete();
        first_log.delete();
    endtask

    task automatic push(input logic [DN-1:0] d, input logic s);
        bit acc;
        int n;
        pix_data = d;
        pix_sof = s;
        pix_valid = 1'b1;
        acc = 0;
        n = 0;
        while (!acc && n < 300) begin
            @(negedge clkSYS);
            acc = pix_ready;
            tick();
            n++;
        end
        if (!acc) fail("push_timeout");
        pix_valid = 1'b0;
        pix_sof = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 1000) begin
            tick();
            n++;
        end
        if (busy) fail("drain_timeout");
        repeat (3) tick();
    endtask

    task automatic log_chk(input string name, input int idx, input logic [AN-1:0] a,
                           input logic [DN-1:0] d);
        if (idx < addr_log.size() && idx < first_log.size()) begin
            chk({name, "_addr"}, 32'(addr_log[idx]), 32'(a));
            chk({name, "_first"}, 32'(first_log[idx]), 32'(d));
        end else begin
            fail({name, "_missing"});
        end
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int cnt;
        int n;

        // 1: single sof burst, ack 3 cycles after request
        ack_delay = 3;
        do_reset();
        chk("t1_ready_after_reset", 32'(pix_ready), 32'd1);
        for (int i = 1; i <= 8; i++) push(16'(i), i == 1);
        wait_idle();
        chk("t1_nbursts", addr_log.size(), 32'd1);
        log_chk("t1_b0", 0, 24'hfa0000, 16'h0001);

        // 2: two bursts queued behind a slow arbiter
        ack_delay = 20;
        do_reset();
        for (int i = 0; i < 16; i++) push(16'h2000 + 16'(i), i == 0);
        @(negedge clkSYS);
        chk("t2_full_ready", 32'(pix_ready), 32'd0);
        wait_idle();
        log_chk("t2_b0", 0, 24'hfa0000, 16'h2000);
        log_chk("t2_b1", 1, 24'hfa0008, 16'h2008);

        // 3: partial words discarded by a mid-slot sof
        ack_delay = 1;
        do_reset();
        for (int i = 0; i < 5; i++) push(16'h1100 + 16'(i), 1'b0);
        push(16'haaaa, 1'b1);
        for (int i = 1; i < 8; i++) push(16'haaaa + 16'(i), 1'b0);
        wait_idle();
        chk("t3_nbursts", addr_log.size(), 32'd1);
        log_chk("t3_b0", 0, 24'hfa0000, 16'haaaa);
`ifdef FB_WRITER_STATS_EN
        chk("t3_drop_cnt", 32'(drop_cnt), 32'd5);
        chk("t3_frame_cnt", 32'(frame_cnt), 32'd1);
`endif

        // 4: one full frame then one more burst wraps the address
        ack_delay = 2;
        do_reset();
        for (int i = 0; i < 40; i++) push(16'h4000 + 16'(i), i == 0);
        wait_idle();
        chk("t4_nbursts", addr_log.size(), 32'd5);
        log_chk("t4_b3", 3, 24'hfa0018, 16'h4018);
        log_chk("t4_b4", 4, 24'hfa0000, 16'h4020);

        // 5: reset in the middle of the data phase
        ack_delay = 1;
        do_reset();
        for (int i = 0; i < 8; i++) push(16'h3000 + 16'(i), i == 0);
        cnt = 0;
        n = 0;
        while (cnt < 3 && n < 200) begin
            @(negedge clkSYS);
            if (wr_valid) cnt++;
            n++;
        end
        if (cnt < 3) fail("t5_data_phase");
        tick();
        reset = 1'b1;
        @(negedge clkSYS);
        chk("t5_ready_in_reset", 32'(pix_ready), 32'd0);
        tick();
        @(negedge clkSYS);
        chk("t5_wr_valid_after_rst", 32'(wr_valid), 32'd0);
        chk("t5_request_after_rst", 32'(request), 32'd0);
        tick();
        reset = 1'b0;
        tick();
        addr_log.delete();
        first_log.delete();
        for (int i = 0; i < 8; i++) push(16'h5000 + 16'(i), i == 0);
        wait_idle();
        chk("t5_nbursts", addr_log.size(), 32'd1);
        log_chk("t5_b0", 0, 24'hfa0000, 16'h5000);

        // 6: continuous stream, push and pop overlapping near full
        ack_delay = 0;
        do_reset();
        for (int i = 0; i < 40; i++) push(16'h6000 + 16'(i), i == 0);
        wait_idle();
        chk("t6_nbursts", addr_log.size(), 32'd5);
        log_chk("t6_b1", 1, 24'hfa0008, 16'h6008);
        log_chk("t6_b4", 4, 24'hfa0000, 16'h6020);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
